// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 32-bit ALU datapath.
// Decodes the MIPS opcode/funct into a 4-bit ALU operation and selects operand B.
// It registers the operands and control signals for EX.
// It also detects load-use hazards and handles downstream hold and flush.
module id_ex_stage #(
  parameter int          WORD_W = 32,
  parameter int          REG_W  = 5,
  parameter logic [3:0]  NOP_OP = 4'b1111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [WORD_W-1:0] rs_data,
  input  logic [WORD_W-1:0] rt_data,
  input  logic              hold,
  input  logic              flush,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [3:0]        ALUOperation,
  output logic [WORD_W-1:0] ALUOperandA,
  output logic [WORD_W-1:0] ALUOperandB,
  output logic [WORD_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_write_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch_eq,
  output logic              ex_branch_ne,
  output logic              ex_illegal
);

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_NOR = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;

  // Decoded control for the instruction currently sitting in ID
  logic [3:0]        w_aluOp;
  logic              w_useImm;
  logic              w_signExt;
  logic [REG_W-1:0]  w_dest;
  logic              w_memRead;
  logic              w_memWrite;
  logic              w_branchEq;
  logic              w_branchNe;
  logic              w_illegal;
  logic              w_rsUsed;
  logic              w_rtUsed;
  logic [WORD_W-1:0] w_immExt;
  logic [WORD_W-1:0] w_operandB;
  logic              w_loadUse;
  logic              w_loadBubble;
  logic              w_loadInstr;

  // EX-stage registers
  logic              r_exValid;
  logic [3:0]        r_aluOp;
  logic [WORD_W-1:0] r_operandA;
  logic [WORD_W-1:0] r_operandB;
  logic [WORD_W-1:0] r_storeData;
  logic [REG_W-1:0]  r_writeReg;
  logic              r_regWrite;
  logic              r_memRead;
  logic              r_memWrite;
  logic              r_branchEq;
  logic              r_branchNe;
  logic              r_illegal;

  // Translate opcode/funct into ALU op, operand-B source, destination and operand usage
  always_comb begin
    w_aluOp    = NOP_OP;
    w_useImm   = 1'b0;
    w_signExt  = 1'b0;
    w_dest     = '0;
    w_memRead  = 1'b0;
    w_memWrite = 1'b0;
    w_branchEq = 1'b0;
    w_branchNe = 1'b0;
    w_illegal  = 1'b0;
    w_rsUsed   = 1'b0;
    w_rtUsed   = 1'b0;
    case (opcode)
      6'h00: begin
        w_rsUsed = 1'b1;
        w_rtUsed = 1'b1;
        w_dest   = rd;
        case (funct)
          6'h20, 6'h21: w_aluOp = ALU_ADD;
          6'h22, 6'h23: w_aluOp = ALU_SUB;
          6'h24:        w_aluOp = ALU_AND;
          6'h25:        w_aluOp = ALU_OR;
          6'h27:        w_aluOp = ALU_NOR;
          default: begin
            w_illegal = 1'b1;
            w_rsUsed  = 1'b0;
            w_rtUsed  = 1'b0;
            w_dest    = '0;
          end
        endcase
      end
      6'h08, 6'h09: begin
        w_aluOp   = ALU_ADD;
        w_useImm  = 1'b1;
        w_signExt = 1'b1;
        w_dest    = rt;
        w_rsUsed  = 1'b1;
      end
      6'h0C: begin
        w_aluOp  = ALU_AND;
        w_useImm = 1'b1;
        w_dest   = rt;
        w_rsUsed = 1'b1;
      end
      6'h0D: begin
        w_aluOp  = ALU_OR;
        w_useImm = 1'b1;
        w_dest   = rt;
        w_rsUsed = 1'b1;
      end
      6'h0F: begin
        w_aluOp  = ALU_LUI;
        w_useImm = 1'b1;
        w_dest   = rt;
      end
      6'h23: begin
        w_aluOp   = ALU_ADD;
        w_useImm  = 1'b1;
        w_signExt = 1'b1;
        w_dest    = rt;
        w_memRead = 1'b1;
        w_rsUsed  = 1'b1;
      end
      6'h2B: begin
        w_aluOp    = ALU_ADD;
        w_useImm   = 1'b1;
        w_signExt  = 1'b1;
        w_memWrite = 1'b1;
        w_rsUsed   = 1'b1;
        w_rtUsed   = 1'b1;
      end
      6'h04: begin
        w_aluOp    = ALU_SUB;
        w_branchEq = 1'b1;
        w_rsUsed   = 1'b1;
        w_rtUsed   = 1'b1;
      end
      6'h05: begin
        w_aluOp    = ALU_SUB;
        w_branchNe = 1'b1;
        w_rsUsed   = 1'b1;
        w_rtUsed   = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Immediate extension, operand-B mux, hazard detection and the load/keep decision
  always_comb begin
    w_immExt     = w_signExt ? {{(WORD_W-16){imm[15]}}, imm} : {{(WORD_W-16){1'b0}}, imm};
    w_operandB   = w_useImm ? w_immExt : rt_data;
    w_loadUse    = r_exValid & r_memRead & (r_writeReg != '0) & id_valid &
                   ((w_rsUsed & (rs == r_writeReg)) | (w_rtUsed & (rt == r_writeReg)));
    w_loadBubble = flush | (~hold & (w_loadUse | ~id_valid));
    w_loadInstr  = ~flush & ~hold & ~w_loadUse & id_valid;
  end

  // EX register: bubble on reset/flush/hazard/empty ID, keep on hold, else take the decoded instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset || w_loadBubble) begin
      r_exValid   <= 1'b0;
      r_aluOp     <= NOP_OP;
      r_operandA  <= '0;
      r_operandB  <= '0;
      r_storeData <= '0;
      r_writeReg  <= '0;
      r_regWrite  <= 1'b0;
      r_memRead   <= 1'b0;
      r_memWrite  <= 1'b0;
      r_branchEq  <= 1'b0;
      r_branchNe  <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_loadInstr) begin
      r_exValid   <= 1'b1;
      r_aluOp     <= w_aluOp;
      r_operandA  <= rs_data;
      r_operandB  <= w_operandB;
      r_storeData <= rt_data;
      r_writeReg  <= w_dest;
      r_regWrite  <= (w_dest != '0);
      r_memRead   <= w_memRead;
      r_memWrite  <= w_memWrite;
      r_branchEq  <= w_branchEq;
      r_branchNe  <= w_branchNe;
      r_illegal   <= w_illegal;
    end
  end

  assign stall_id      = w_loadUse | hold;
  assign ex_valid      = r_exValid;
  assign ALUOperation  = r_aluOp;
  assign ALUOperandA   = r_operandA;
  assign ALUOperandB   = r_operandB;
  assign ex_store_data = r_storeData;
  assign ex_write_reg  = r_writeReg;
  assign ex_reg_write  = r_regWrite;
  assign ex_mem_read   = r_memRead;
  assign ex_mem_write  = r_memWrite;
  assign ex_branch_eq  = r_branchEq;
  assign ex_branch_ne  = r_branchNe;
  assign ex_illegal    = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by randomized traffic,
// each compared against an instruction-level reference model of the EX register.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] store;
    logic [4:0]  wreg;
    logic        regw;
    logic        memr;
    logic        memw;
    logic        beq;
    logic        bne;
    logic        ill;
  } exState_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rsd;
    logic [31:0] rtd;
  } inst_t;

  localparam exState_t BUBBLE = '{valid: 1'b0, op: 4'hF, a: 32'd0, b: 32'd0, store: 32'd0,
                                  wreg: 5'd0, regw: 1'b0, memr: 1'b0, memw: 1'b0,
                                  beq: 1'b0, bne: 1'b0, ill: 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hold;
  logic        flush;
  logic        stall_id;
  logic        ex_valid;
  logic [3:0]  ALUOperation;
  logic [31:0] ALUOperandA;
  logic [31:0] ALUOperandB;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch_eq;
  logic        ex_branch_ne;
  logic        ex_illegal;

  exState_t dutState;
  exState_t mdl;
  int       checkCount = 0;
  int       passCount  = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .imm(imm), .rs(rs), .rt(rt), .rd(rd), .rs_data(rs_data), .rt_data(rt_data),
    .hold(hold), .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
    .ALUOperation(ALUOperation), .ALUOperandA(ALUOperandA), .ALUOperandB(ALUOperandB),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch_eq(ex_branch_eq),
    .ex_branch_ne(ex_branch_ne), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  assign dutState = {ex_valid, ALUOperation, ALUOperandA, ALUOperandB, ex_store_data,
                     ex_write_reg, ex_reg_write, ex_mem_read, ex_mem_write,
                     ex_branch_eq, ex_branch_ne, ex_illegal};

  // Instruction-level meaning of each MIPS encoding as it should appear in EX
  function automatic exState_t refDecode(input inst_t in);
    exState_t    e;
    logic [31:0] sImm;
    logic [31:0] zImm;
    logic [4:0]  dest;
    sImm = {{16{in.imm[15]}}, in.imm};
    zImm = {16'h0000, in.imm};
    e = BUBBLE;
    e.valid = 1'b1;
    e.a = in.rsd;
    e.b = in.rtd;
    e.store = in.rtd;
    dest = 5'd0;
    if (in.opcode == 6'h00) begin
      dest = in.rd;
      if (in.funct == 6'h20 || in.funct == 6'h21)      e.op = 4'd3;
      else if (in.funct == 6'h22 || in.funct == 6'h23) e.op = 4'd4;
      else if (in.funct == 6'h24)                      e.op = 4'd0;
      else if (in.funct == 6'h25)                      e.op = 4'd1;
      else if (in.funct == 6'h27)                      e.op = 4'd2;
      else                                             e.ill = 1'b1;
    end else if (in.opcode == 6'h08 || in.opcode == 6'h09) begin
      e.op = 4'd3; e.b = sImm; dest = in.rt;
    end else if (in.opcode == 6'h0C) begin
      e.op = 4'd0; e.b = zImm; dest = in.rt;
    end else if (in.opcode == 6'h0D) begin
      e.op = 4'd1; e.b = zImm; dest = in.rt;
    end else if (in.opcode == 6'h0F) begin
      e.op = 4'd5; e.b = zImm; dest = in.rt;
    end else if (in.opcode == 6'h23) begin
      e.op = 4'd3; e.b = sImm; dest = in.rt; e.memr = 1'b1;
    end else if (in.opcode == 6'h2B) begin
      e.op = 4'd3; e.b = sImm; e.memw = 1'b1;
    end else if (in.opcode == 6'h04) begin
      e.op = 4'd4; e.beq = 1'b1;
    end else if (in.opcode == 6'h05) begin
      e.op = 4'd4; e.bne = 1'b1;
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) begin
      e.op = 4'hF;
      dest = 5'd0;
    end
    e.wreg = dest;
    e.regw = (dest != 5'd0);
    return e;
  endfunction

  // A load in EX whose destination is read by the ID instruction forces one bubble
  function automatic logic refLoadUse(input exState_t ex, input inst_t in);
    exState_t d;
    logic     rsRead;
    logic     rtRead;
    d = refDecode(in);
    rsRead = !d.ill && in.opcode != 6'h0F;
    rtRead = !d.ill && (in.opcode == 6'h00 || in.opcode == 6'h2B ||
                        in.opcode == 6'h04 || in.opcode == 6'h05);
    return ex.valid && ex.memr && ex.wreg != 5'd0 && in.valid &&
           ((rsRead && in.rs == ex.wreg) || (rtRead && in.rt == ex.wreg));
  endfunction

  function automatic inst_t mkInst(input logic v, input logic [5:0] op, input logic [5:0] fn,
                                   input logic [15:0] im, input logic [4:0] s,
                                   input logic [4:0] t, input logic [4:0] d,
                                   input logic [31:0] sd, input logic [31:0] td);
    inst_t i;
    i.valid = v; i.opcode = op; i.funct = fn; i.imm = im;
    i.rs = s; i.rt = t; i.rd = d; i.rsd = sd; i.rtd = td;
    return i;
  endfunction

  task automatic checkOutput(input string tag, input logic [111:0] obs, input logic [111:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one ID slot, check stall_id before the edge and the EX state after it
  task automatic applyStimulus(input string tag, input inst_t in, input logic h,
                               input logic f, output logic stallExp);
    logic     lu;
    exState_t nxt;
    id_valid = in.valid; opcode = in.opcode; funct = in.funct; imm = in.imm;
    rs = in.rs; rt = in.rt; rd = in.rd; rs_data = in.rsd; rt_data = in.rtd;
    hold = h; flush = f;
    #2;
    lu = refLoadUse(mdl, in);
    stallExp = lu | h;
    checkOutput({tag, ".stall"}, {111'd0, stall_id}, {111'd0, stallExp});
    if (f)                  nxt = BUBBLE;
    else if (h)             nxt = mdl;
    else if (lu || !in.valid) nxt = BUBBLE;
    else                    nxt = refDecode(in);
    @(posedge clk);
    mdl = nxt;
    #1;
    checkOutput({tag, ".ex"}, dutState, mdl);
  endtask

  initial begin
    logic       st;
    inst_t      cur;
    logic [5:0] opList [12];
    logic [5:0] fnList [8];
    opList = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05};
    fnList = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h26};

    reset = 1'b1; id_valid = 1'b0; opcode = '0; funct = '0; imm = '0;
    rs = '0; rt = '0; rd = '0; rs_data = '0; rt_data = '0; hold = 1'b0; flush = 1'b0;
    mdl = BUBBLE;
    #12;
    checkOutput("reset.ex", dutState, BUBBLE);
    checkOutput("reset.stall", {111'd0, stall_id}, 112'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // add $3 = $1 + $2 with rs_data=5, rt_data=7
    applyStimulus("add", mkInst(1, 6'h00, 6'h20, 16'h0000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7), 0, 0, st);
    checkOutput("add.op", {108'd0, ALUOperation}, {108'd0, 4'd3});
    checkOutput("add.B", {80'd0, ALUOperandB}, {80'd0, 32'd7});
    checkOutput("add.wreg", {107'd0, ex_write_reg}, {107'd0, 5'd3});

    // Reset in the middle of a cycle wipes EX before the next edge
    #3 reset = 1'b1; id_valid = 1'b0;
    #1;
    checkOutput("midreset.ex", dutState, BUBBLE);
    checkOutput("midreset.stall", {111'd0, stall_id}, 112'd0);
    mdl = BUBBLE;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Immediate extension variants
    applyStimulus("addi", mkInst(1, 6'h08, 6'h00, 16'hFFFF, 5'd1, 5'd4, 5'd0, 32'd9, 32'd1), 0, 0, st);
    checkOutput("addi.B", {80'd0, ALUOperandB}, {80'd0, 32'hFFFF_FFFF});
    applyStimulus("ori", mkInst(1, 6'h0D, 6'h00, 16'hFFFF, 5'd1, 5'd4, 5'd0, 32'd9, 32'd1), 0, 0, st);
    checkOutput("ori.B", {80'd0, ALUOperandB}, {80'd0, 32'h0000_FFFF});
    applyStimulus("lui", mkInst(1, 6'h0F, 6'h00, 16'h1234, 5'd0, 5'd6, 5'd0, 32'd9, 32'd1), 0, 0, st);
    checkOutput("lui.op", {108'd0, ALUOperation}, {108'd0, 4'd5});
    checkOutput("lui.B", {80'd0, ALUOperandB}, {80'd0, 32'h0000_1234});
    applyStimulus("sw", mkInst(1, 6'h2B, 6'h00, 16'h8000, 5'd1, 5'd7, 5'd0, 32'd4, 32'hCAFE), 0, 0, st);
    checkOutput("sw.store", {80'd0, ex_store_data}, {80'd0, 32'hCAFE});
    applyStimulus("beq", mkInst(1, 6'h04, 6'h00, 16'h0010, 5'd1, 5'd2, 5'd0, 32'd4, 32'd4), 0, 0, st);

    // lw $2 then add using $2: one stall cycle, bubble, then the add
    applyStimulus("lw2", mkInst(1, 6'h23, 6'h00, 16'h0004, 5'd1, 5'd2, 5'd0, 32'h100, 32'd0), 0, 0, st);
    applyStimulus("lu.a", mkInst(1, 6'h00, 6'h20, 16'h0, 5'd2, 5'd1, 5'd5, 32'd11, 32'd12), 0, 0, st);
    checkOutput("lu.stall1", {111'd0, st}, 112'd1);
    checkOutput("lu.bubble", {111'd0, ex_valid}, 112'd0);
    applyStimulus("lu.b", mkInst(1, 6'h00, 6'h20, 16'h0, 5'd2, 5'd1, 5'd5, 32'd11, 32'd12), 0, 0, st);
    checkOutput("lu.valid", {111'd0, ex_valid}, 112'd1);

    // lw $0 followed by a use of $0 never stalls
    applyStimulus("lw0", mkInst(1, 6'h23, 6'h00, 16'h0004, 5'd1, 5'd0, 5'd0, 32'h100, 32'd0), 0, 0, st);
    applyStimulus("use0", mkInst(1, 6'h00, 6'h25, 16'h0, 5'd0, 5'd0, 5'd6, 32'd1, 32'd2), 0, 0, st);
    // lui writing $2 right after lw $2 reads neither register
    applyStimulus("lw2b", mkInst(1, 6'h23, 6'h00, 16'h0008, 5'd1, 5'd2, 5'd0, 32'h200, 32'd0), 0, 0, st);
    applyStimulus("lui2", mkInst(1, 6'h0F, 6'h00, 16'hABCD, 5'd2, 5'd2, 5'd0, 32'd1, 32'd2), 0, 0, st);

    // Hold for three cycles, then flush together with hold
    applyStimulus("pre", mkInst(1, 6'h00, 6'h27, 16'h0, 5'd1, 5'd2, 5'd8, 32'hF0F0, 32'h0F00), 0, 0, st);
    for (int i = 0; i < 3; i++)
      applyStimulus("hold", mkInst(1, 6'h0C, 6'h00, 16'h1111, 5'd3, 5'd4, 5'd0, 32'd77, 32'd88), 1, 0, st);
    checkOutput("hold.wreg", {107'd0, ex_write_reg}, {107'd0, 5'd8});
    applyStimulus("flushhold", mkInst(1, 6'h0C, 6'h00, 16'h1111, 5'd3, 5'd4, 5'd0, 32'd77, 32'd88), 1, 1, st);
    checkOutput("flush.valid", {111'd0, ex_valid}, 112'd0);

    // Illegal opcode
    applyStimulus("ill", mkInst(1, 6'h3F, 6'h00, 16'h0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2), 0, 0, st);
    checkOutput("ill.flag", {111'd0, ex_illegal}, 112'd1);
    checkOutput("ill.op", {108'd0, ALUOperation}, {108'd0, 4'hF});
    applyStimulus("idle", mkInst(0, 6'h00, 6'h20, 16'h0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2), 0, 0, st);

    // Randomized traffic over a small register set to provoke hazards
    st = 1'b0;
    cur = mkInst(0, 6'h00, 6'h20, 16'h0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    for (int n = 0; n < 200; n++) begin
      if (!st) begin
        cur.valid  = ($urandom_range(0, 7) != 0);
        cur.opcode = ($urandom_range(0, 15) == 0) ? 6'h3F : opList[$urandom_range(0, 11)];
        cur.funct  = fnList[$urandom_range(0, 7)];
        cur.imm    = 16'($urandom);
        cur.rs     = 5'($urandom_range(0, 3));
        cur.rt     = 5'($urandom_range(0, 3));
        cur.rd     = 5'($urandom_range(0, 3));
        cur.rsd    = $urandom;
        cur.rtd    = $urandom;
      end
      applyStimulus("rand", cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), st);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
